// File: rtl/sram_port_ctrl_pkg.sv
// Shared definitions for the SRAM port controller and the SRAM it drives:
// default bus widths and the controller state encoding.
package sram_port_ctrl_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_TURN  = 3'd3,
    ST_READ  = 3'd4
  } state_t;

endpackage

// File: rtl/sram_port_ctrl.sv
// Host-side controller for a single-port tristate SRAM. Turns valid/ready
// requests into cs/we/oe/address/bus-drive sequences, captures read data,
// inserts a turnaround cycle between a write and a following read, and can
// zero the whole RAM after reset before accepting traffic.
module sram_port_ctrl #(
  parameter int DATA_WIDTH     = sram_port_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH     = sram_port_ctrl_pkg::ADDR_WIDTH,
  parameter int RAM_DEPTH      = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  import sram_port_ctrl_pkg::*;

  // One extra counter bit so RAM_DEPTH == 2**ADDR_WIDTH ends without wrapping.
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_last_wr;
  logic                  r_pend_rd;
  logic                  r_drv;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_accept;
  logic                  w_addr_ok;
  logic                  w_cs;
  logic                  w_we;
  logic                  w_oe;
  logic                  w_drv;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_bus;

  assign w_accept  = req_valid && req_ready;
  assign w_addr_ok = {1'b0, req_addr} < LP_DEPTH;
  // During the clear sequence the bus carries zeros, otherwise the latched write data.
  assign w_bus     = (r_state == ST_INIT) ? '0 : r_wdata;
  assign ram_data  = r_drv ? w_bus : 'z;

  // Next state plus the SRAM control pattern to present while in that state.
  always_comb begin
    w_next = r_state;
    w_cs   = 1'b0;
    w_we   = 1'b0;
    w_oe   = 1'b0;
    w_drv  = 1'b0;
    w_addr = ram_addr;
    case (r_state)
      ST_INIT: begin
        if (!CLEAR_ON_RESET) begin
          w_next = ST_IDLE;
        end else if (r_cnt < LP_DEPTH) begin
          w_cs   = 1'b1;
          w_we   = 1'b1;
          w_drv  = 1'b1;
          w_addr = r_cnt[ADDR_WIDTH-1:0];
        end else begin
          w_next = ST_TURN;
        end
      end
      ST_IDLE: begin
        // Out-of-range requests never touch the RAM and leave us in IDLE.
        if (w_accept && w_addr_ok) begin
          w_addr = req_addr;
          if (req_we) begin
            w_next = ST_WRITE;
            w_cs   = 1'b1;
            w_we   = 1'b1;
            w_drv  = 1'b1;
          end else if (r_last_wr) begin
            w_next = ST_TURN;
          end else begin
            w_next = ST_READ;
            w_cs   = 1'b1;
            w_oe   = 1'b1;
          end
        end
      end
      ST_TURN: begin
        // TURN also follows the clear sequence, where no read is pending.
        if (r_pend_rd) begin
          w_next = ST_READ;
          w_cs   = 1'b1;
          w_oe   = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Registered FSM, SRAM controls, handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      r_last_wr <= 1'b0;
      r_pend_rd <= 1'b0;
      r_drv     <= 1'b0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      r_state   <= w_next;
      ram_cs    <= w_cs;
      ram_we    <= w_we;
      ram_oe    <= w_oe;
      r_drv     <= w_drv;
      ram_addr  <= w_addr;
      req_ready <= (w_next == ST_IDLE);
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (CLEAR_ON_RESET && (r_cnt < LP_DEPTH)) r_cnt <= r_cnt + 1'b1;
          if (w_next != ST_INIT) begin
            init_done <= 1'b1;
            r_last_wr <= CLEAR_ON_RESET;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            if (!w_addr_ok) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              r_pend_rd <= !req_we;
            end
          end
        end
        ST_WRITE: r_last_wr <= 1'b1;
        ST_READ: begin
          // SRAM output settled on the mid-cycle negedge; sample on the closing edge.
          rsp_valid <= 1'b1;
          rsp_rdata <= ram_data;
          r_last_wr <= 1'b0;
          r_pend_rd <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Write data latch; only meaningful while a write is in flight.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && w_accept && req_we) r_wdata <= req_wdata;
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: two controllers (RAM_DEPTH 16 and 12), each with a
// behavioural tristate SRAM, checked against a word-array reference model.
module tb_sram_port_ctrl;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- instance A: RAM_DEPTH = 16 ----------------
  logic        rst_n;
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [3:0]  a_req_addr;
  logic [15:0] a_req_wdata;
  logic        a_rsp_valid, a_rsp_err, a_init_done;
  logic [15:0] a_rsp_rdata;
  logic [3:0]  a_ram_addr;
  logic        a_ram_cs, a_ram_we, a_ram_oe;
  wire  [15:0] a_ram_data;

  sram_port_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RAM_DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .init_done(a_init_done),
    .ram_addr(a_ram_addr), .ram_cs(a_ram_cs), .ram_we(a_ram_we), .ram_oe(a_ram_oe),
    .ram_data(a_ram_data)
  );

  // ---------------- instance B: RAM_DEPTH = 12 ----------------
  logic        b_rst_n;
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [3:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_err, b_init_done;
  logic [15:0] b_rsp_rdata;
  logic [3:0]  b_ram_addr;
  logic        b_ram_cs, b_ram_we, b_ram_oe;
  wire  [15:0] b_ram_data;

  sram_port_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RAM_DEPTH(12), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .init_done(b_init_done),
    .ram_addr(b_ram_addr), .ram_cs(b_ram_cs), .ram_we(b_ram_we), .ram_oe(b_ram_oe),
    .ram_data(b_ram_data)
  );

  // ---------------- behavioural SRAMs ----------------
  logic [15:0] a_mem [16];
  logic [15:0] b_mem [16];
  logic [15:0] a_sout, b_sout;
  logic        a_sdrv = 1'b0;
  logic        b_sdrv = 1'b0;
  bit          seeded = 1'b0;

  assign a_ram_data = a_sdrv ? a_sout : 'z;
  assign b_ram_data = b_sdrv ? b_sout : 'z;

  // SRAM write port: commit on posedge with cs&we; seed nonzero junk first.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!seeded) begin
      for (int i = 0; i < 16; i++) begin
        a_mem[i] <= 16'hDE00 | 16'(i);
        b_mem[i] <= 16'hBE00 | 16'(i);
      end
      seeded <= 1'b1;
    end else begin
      if (a_ram_cs && a_ram_we) a_mem[a_ram_addr] <= a_ram_data;
      if (b_ram_cs && b_ram_we) b_mem[b_ram_addr] <= b_ram_data;
    end
  end

  // SRAM read port: drive the bus from the negedge of a cs&oe cycle.
  always @(negedge clk) begin
    if (a_ram_cs && a_ram_oe && !a_ram_we) begin a_sout <= a_mem[a_ram_addr]; a_sdrv <= 1'b1; end
    else a_sdrv <= 1'b0;
    if (b_ram_cs && b_ram_oe && !b_ram_we) begin b_sout <= b_mem[b_ram_addr]; b_sdrv <= 1'b1; end
    else b_sdrv <= 1'b0;
  end

  // Protocol monitor: we/oe exclusivity, bus contention, B clear-sequence tally.
  int excl_viol = 0;
  int conflict_viol = 0;
  int b_init_cnt = 0;
  logic [3:0] b_last_init_addr = 4'd0;
  always @(negedge clk) begin
    if ((a_ram_we && a_ram_oe) || (b_ram_we && b_ram_oe)) excl_viol <= excl_viol + 1;
    if ((dut_a.r_drv && a_sdrv) || (dut_b.r_drv && b_sdrv)) conflict_viol <= conflict_viol + 1;
    if (b_rst_n && !b_init_done && b_ram_cs) begin
      b_init_cnt       <= b_init_cnt + 1;
      b_last_init_addr <= b_ram_addr;
    end
  end

  // ---------------- reference model for A ----------------
  logic [15:0] m_mem [16];
  logic        m_last_wr = 1'b0;
  int          last_rsp_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Clear sequence after reset release (called on the releasing negedge).
  task automatic run_init();
    for (int i = 0; i < 16; i++) begin
      a_req_valid = 1'b1;
      a_req_we    = 1'($urandom);
      a_req_addr  = 4'($urandom);
      a_req_wdata = 16'($urandom);
      @(negedge clk);
      chk("init_cs",    32'(a_ram_cs),    32'(1));
      chk("init_we",    32'(a_ram_we),    32'(1));
      chk("init_addr",  32'(a_ram_addr),  32'(i));
      chk("init_data",  32'(a_ram_data),  32'(0));
      chk("init_ready", 32'(a_req_ready), 32'(0));
      chk("init_done0", 32'(a_init_done), 32'(0));
      chk("init_rsp",   32'(a_rsp_valid), 32'(0));
    end
    @(negedge clk);
    chk("init_done1",  32'(a_init_done), 32'(1));
    chk("init_end_cs", 32'(a_ram_cs),    32'(0));
    chk("init_end_rdy",32'(a_req_ready), 32'(0));
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
    m_last_wr = 1'b1;
  endtask

  task automatic do_req(input logic we, input logic [3:0] addr, input logic [15:0] wd);
    int n;
    int lat;
    logic exp_lw;
    a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!a_req_ready) begin
      chk("accept_timeout", 32'(n), 32'(0));
      a_req_valid = 1'b0;
      return;
    end
    exp_lw = m_last_wr;
    @(negedge clk);
    a_req_valid = 1'b0;
    if (we) begin
      chk("wr_cs",    32'(a_ram_cs),    32'(1));
      chk("wr_we",    32'(a_ram_we),    32'(1));
      chk("wr_addr",  32'(a_ram_addr),  32'(addr));
      chk("wr_data",  32'(a_ram_data),  32'(wd));
      chk("wr_norsp", 32'(a_rsp_valid), 32'(0));
      m_mem[addr] = wd;
      m_last_wr   = 1'b1;
    end else begin
      chk("rd_cs1",   32'(a_ram_cs),    32'(exp_lw ? 0 : 1));
      chk("rd_oe1",   32'(a_ram_oe),    32'(exp_lw ? 0 : 1));
      chk("rd_drv1",  32'(dut_a.r_drv), 32'(0));
      chk("rd_norsp", 32'(a_rsp_valid), 32'(0));
      lat = 1;
      while (!a_rsp_valid && lat < 8) begin @(negedge clk); lat++; end
      chk("rd_lat",  32'(lat),         32'(exp_lw ? 3 : 2));
      chk("rd_data", 32'(a_rsp_rdata), 32'(m_mem[addr]));
      chk("rd_err",  32'(a_rsp_err),   32'(0));
      last_rsp_cyc = cyc;
      m_last_wr    = 1'b0;
    end
  endtask

  // B request: observes four cycles after acceptance for cs activity and the response.
  task automatic b_do_req(input logic we, input logic [3:0] addr, input logic [15:0] wd,
                          output int cs_seen, output int rsp_at,
                          output logic err, output logic [15:0] rd);
    int n;
    cs_seen = 0; rsp_at = 0; err = 1'b0; rd = b_rsp_rdata;
    b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_valid = 1'b1;
    n = 0;
    while (!b_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!b_req_ready) begin
      chk("b_accept_timeout", 32'(n), 32'(0));
      b_req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    b_req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (b_ram_cs) cs_seen = 1;
      if (b_rsp_valid && rsp_at == 0) begin rsp_at = k; err = b_rsp_err; rd = b_rsp_rdata; end
      if (k < 4) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=no_finish expected=finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    int cs_seen;
    int rsp_at;
    logic err;
    logic [15:0] rd;

    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    rst_n = 1'b0; b_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs",    32'(a_ram_cs),    32'(0));
    chk("rst_addr",  32'(a_ram_addr),  32'(0));
    chk("rst_drv",   32'(dut_a.r_drv), 32'(0));
    chk("rst_ready", 32'(a_req_ready), 32'(0));
    chk("rst_done",  32'(a_init_done), 32'(0));
    chk("rst_rsp",   32'(a_rsp_valid), 32'(0));
    chk("rst_rdata", 32'(a_rsp_rdata), 32'(0));
    rst_n = 1'b1; b_rst_n = 1'b1;
    run_init();

    // Cleared contents, write-then-read with turnaround.
    do_req(1'b0, 4'd3, 16'h0);
    do_req(1'b0, 4'd15, 16'h0);
    do_req(1'b1, 4'd5, 16'hA5A5);
    do_req(1'b0, 4'd5, 16'h0);

    // Back-to-back reads with no turnaround: responses two cycles apart.
    do_req(1'b1, 4'd2, 16'h1111);
    do_req(1'b1, 4'd7, 16'h7777);
    do_req(1'b0, 4'd2, 16'h0);
    t0 = last_rsp_cyc;
    do_req(1'b0, 4'd7, 16'h0);
    chk("b2b_spacing", 32'(last_rsp_cyc - t0), 32'(2));

    for (int k = 0; k < 40; k++)
      do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));

    // Reset in the middle of a READ cycle.
    do_req(1'b0, 4'd2, 16'h0);
    a_req_we = 1'b0; a_req_addr = 4'd4; a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("mr_cs", 32'(a_ram_cs), 32'(1));
    chk("mr_oe", 32'(a_ram_oe), 32'(1));
    #1 rst_n = 1'b0; a_req_valid = 1'b0;
    #1;
    chk("mr_cs_low",  32'(a_ram_cs),    32'(0));
    chk("mr_oe_low",  32'(a_ram_oe),    32'(0));
    chk("mr_drv_low", 32'(dut_a.r_drv), 32'(0));
    chk("mr_ready",   32'(a_req_ready), 32'(0));
    chk("mr_done",    32'(a_init_done), 32'(0));
    repeat (3) begin
      @(negedge clk);
      chk("mr_norsp", 32'(a_rsp_valid), 32'(0));
      chk("mr_cs_off", 32'(a_ram_cs),   32'(0));
    end
    rst_n = 1'b1;
    run_init();
    do_req(1'b0, 4'd4, 16'h0);

    // Instance B: RAM_DEPTH 12, out-of-range handling.
    chk("b_init_done", 32'(b_init_done),      32'(1));
    chk("b_init_cnt",  32'(b_init_cnt),       32'(12));
    chk("b_init_last", 32'(b_last_init_addr), 32'(11));
    b_do_req(1'b1, 4'd1, 16'h0BAD, cs_seen, rsp_at, err, rd);
    chk("b_wr_cs",  32'(cs_seen), 32'(1));
    chk("b_wr_rsp", 32'(rsp_at),  32'(0));
    b_do_req(1'b0, 4'd1, 16'h0, cs_seen, rsp_at, err, rd);
    chk("b_rd1_lat",  32'(rsp_at), 32'(3));
    chk("b_rd1_err",  32'(err),    32'(0));
    chk("b_rd1_data", 32'(rd),     32'(16'h0BAD));
    b_do_req(1'b1, 4'd13, 16'hFFFF, cs_seen, rsp_at, err, rd);
    chk("b_oor_wr_cs",   32'(cs_seen), 32'(0));
    chk("b_oor_wr_lat",  32'(rsp_at),  32'(1));
    chk("b_oor_wr_err",  32'(err),     32'(1));
    chk("b_oor_wr_data", 32'(rd),      32'(16'h0BAD));
    b_do_req(1'b0, 4'd12, 16'h0, cs_seen, rsp_at, err, rd);
    chk("b_oor_rd_cs",  32'(cs_seen), 32'(0));
    chk("b_oor_rd_lat", 32'(rsp_at),  32'(1));
    chk("b_oor_rd_err", 32'(err),     32'(1));
    b_do_req(1'b0, 4'd1, 16'h0, cs_seen, rsp_at, err, rd);
    chk("b_rd2_lat",  32'(rsp_at), 32'(2));
    chk("b_rd2_err",  32'(err),    32'(0));
    chk("b_rd2_data", 32'(rd),     32'(16'h0BAD));

    @(negedge clk);
    chk("we_oe_exclusive", 32'(excl_viol),     32'(0));
    chk("bus_contention",  32'(conflict_viol), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
